// File: rtl/vx_mem_model_pkg.sv
// Shared types for the external memory model: request/response bundles and counter width.
// Struct fields are sized by the package widths, so responders keep their width parameters at these defaults.
package vx_mem_model_pkg;

    localparam int MEM_MODEL_CTR_W = 32;
    localparam int MEM_DATA_W      = 512;
    localparam int MEM_ADDR_W      = 26;
    localparam int MEM_TAG_W       = 8;
    localparam int MEM_BYTEEN_W    = MEM_DATA_W / 8;

    typedef struct packed {
        logic                    rw;
        logic [MEM_BYTEEN_W-1:0] byteen;
        logic [MEM_ADDR_W-1:0]   addr;
        logic [MEM_DATA_W-1:0]   data;
        logic [MEM_TAG_W-1:0]    tag;
    } mem_req_t;

    typedef struct packed {
        logic [MEM_DATA_W-1:0] data;
        logic [MEM_TAG_W-1:0]  tag;
    } mem_rsp_t;

endpackage

// File: rtl/vx_mem_responder_queue.sv
// Response FIFO, head read straight from storage flops; push into empty shows at the head next cycle.
// Push is taken when not full or when popping in the same cycle; the credit scheme upstream prevents overflow.
module vx_mem_responder_queue #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_head_dat,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_do_pop   = i_pop & ~o_empty;
    assign w_do_push  = i_push & (~o_full | w_do_pop);
    assign o_head_dat = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // When full, a simultaneous pop frees the slot the write pointer lands on.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(i_push && o_full && !i_pop));

endmodule

// File: rtl/vx_mem_responder.sv
// Line-addressed memory responder: byte-enable writes, tagged reads returned LATENCY cycles after accept.
// Backpressure: mem_req_ready drops once RSP_QUEUE_SIZE reads are outstanding; responses wait in an in-order queue.
module vx_mem_responder
    import vx_mem_model_pkg::*;
#(
    parameter int DATA_WIDTH     = MEM_DATA_W,
    parameter int ADDR_WIDTH     = MEM_ADDR_W,
    parameter int TAG_WIDTH      = MEM_TAG_W,
    parameter int RAM_ADDR_WIDTH = 10,
    parameter int LATENCY        = 4,
    parameter int RSP_QUEUE_SIZE = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_req_valid,
    input  logic                       mem_req_rw,
    input  logic [DATA_WIDTH/8-1:0]    mem_req_byteen,
    input  logic [ADDR_WIDTH-1:0]      mem_req_addr,
    input  logic [DATA_WIDTH-1:0]      mem_req_data,
    input  logic [TAG_WIDTH-1:0]       mem_req_tag,
    output logic                       mem_req_ready,
    output logic                       mem_rsp_valid,
    output logic [DATA_WIDTH-1:0]      mem_rsp_data,
    output logic [TAG_WIDTH-1:0]       mem_rsp_tag,
    input  logic                       mem_rsp_ready,
    output logic                       busy,
    output logic [MEM_MODEL_CTR_W-1:0] perf_reads,
    output logic [MEM_MODEL_CTR_W-1:0] perf_writes
);

    localparam int BE_W      = DATA_WIDTH / 8;
    localparam int CRD_W     = $clog2(RSP_QUEUE_SIZE + 1);
    localparam int RAM_DEPTH = 2 ** RAM_ADDR_WIDTH;

    mem_req_t                   w_req;
    logic                       w_req_fire;
    logic                       w_wr_fire;
    logic                       w_rd_fire;
    logic                       w_rsp_fire;
    logic [RAM_ADDR_WIDTH-1:0]  w_ram_idx;
    logic                       w_unused_addr_hi;
    mem_rsp_t                   w_rd_ent;
    logic                       w_push_vld;
    mem_rsp_t                   w_push_dat;
    mem_rsp_t                   w_head;
    logic                       w_q_empty;
    logic                       w_unused_q_full;

    logic [DATA_WIDTH-1:0]      r_ram [RAM_DEPTH];
    logic [CRD_W-1:0]           r_outstanding;
    logic [MEM_MODEL_CTR_W-1:0] r_perf_reads;
    logic [MEM_MODEL_CTR_W-1:0] r_perf_writes;

    assign w_req = '{rw:     mem_req_rw,
                     byteen: mem_req_byteen,
                     addr:   mem_req_addr,
                     data:   mem_req_data,
                     tag:    mem_req_tag};

    assign w_req_fire = mem_req_valid & mem_req_ready;
    assign w_wr_fire  = w_req_fire & w_req.rw;
    assign w_rd_fire  = w_req_fire & ~w_req.rw;
    assign w_rsp_fire = mem_rsp_valid & mem_rsp_ready;

    // Upper line-address bits alias onto the local RAM.
    assign w_ram_idx        = w_req.addr[RAM_ADDR_WIDTH-1:0];
    assign w_unused_addr_hi = ^w_req.addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            for (int b = 0; b < BE_W; b++) begin
                if (w_req.byteen[b]) r_ram[w_ram_idx][b*8 +: 8] <= w_req.data[b*8 +: 8];
            end
        end
    end

    assign w_rd_ent = '{data: r_ram[w_ram_idx], tag: w_req.tag};

    // LATENCY-1 register stages; the queue's storage supplies the last cycle.
    generate
        if (LATENCY == 1) begin : g_dl_bypass
            assign w_push_vld = w_rd_fire;
            assign w_push_dat = w_rd_ent;
        end else begin : g_dl
            localparam int STAGES = LATENCY - 1;
            logic [STAGES-1:0] r_dl_vld;
            mem_rsp_t          r_dl_dat [STAGES];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_dl_vld <= '0;
                end else begin
                    r_dl_vld[0] <= w_rd_fire;
                    for (int s = 1; s < STAGES; s++) r_dl_vld[s] <= r_dl_vld[s-1];
                end
            end

            always_ff @(posedge clk) begin
                r_dl_dat[0] <= w_rd_ent;
                for (int s = 1; s < STAGES; s++) r_dl_dat[s] <= r_dl_dat[s-1];
            end

            assign w_push_vld = r_dl_vld[STAGES-1];
            assign w_push_dat = r_dl_dat[STAGES-1];
        end
    endgenerate

    vx_mem_responder_queue #(
        .W     ($bits(mem_rsp_t)),
        .DEPTH (RSP_QUEUE_SIZE)
    ) u_rsp_queue (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push_vld),
        .i_push_dat (w_push_dat),
        .i_pop      (w_rsp_fire),
        .o_head_dat (w_head),
        .o_full     (w_unused_q_full),
        .o_empty    (w_q_empty)
    );

    assign mem_rsp_valid = ~w_q_empty;
    assign mem_rsp_data  = w_head.data;
    assign mem_rsp_tag   = w_head.tag;

    // Credits cover delay line plus queue, so the queue never has to refuse a push.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outstanding <= '0;
        end else begin
            case ({w_rd_fire, w_rsp_fire})
                2'b10:   r_outstanding <= r_outstanding + CRD_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CRD_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign mem_req_ready = (r_outstanding < CRD_W'(RSP_QUEUE_SIZE));
    assign busy          = (r_outstanding != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_reads  <= '0;
            r_perf_writes <= '0;
        end else begin
            if (w_rd_fire) r_perf_reads  <= r_perf_reads + MEM_MODEL_CTR_W'(1);
            if (w_wr_fire) r_perf_writes <= r_perf_writes + MEM_MODEL_CTR_W'(1);
        end
    end

    assign perf_reads  = r_perf_reads;
    assign perf_writes = r_perf_writes;

endmodule

// File: tb/tb_vx_mem_responder.sv
// Directed bench for vx_mem_responder: latency, byte enables, aliasing, credit backpressure, reset flush.
module tb_vx_mem_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_req_valid;
    logic         mem_req_rw;
    logic [63:0]  mem_req_byteen;
    logic [25:0]  mem_req_addr;
    logic [511:0] mem_req_data;
    logic [7:0]   mem_req_tag;
    logic         mem_req_ready;
    logic         mem_rsp_valid;
    logic [511:0] mem_rsp_data;
    logic [7:0]   mem_rsp_tag;
    logic         mem_rsp_ready;
    logic         busy;
    logic [31:0]  perf_reads;
    logic [31:0]  perf_writes;

    int total = 0;
    int bad   = 0;
    int n_rd  = 0;
    int n_wr  = 0;

    logic [511:0] pat_a;
    logic [511:0] pat_b;
    logic [511:0] pat_ff;
    logic [511:0] pat_b0;

    vx_mem_responder #(
        .DATA_WIDTH     (512),
        .ADDR_WIDTH     (26),
        .TAG_WIDTH      (8),
        .RAM_ADDR_WIDTH (10),
        .LATENCY        (4),
        .RSP_QUEUE_SIZE (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_rw     (mem_req_rw),
        .mem_req_byteen (mem_req_byteen),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_tag    (mem_req_tag),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_tag    (mem_rsp_tag),
        .mem_rsp_ready  (mem_rsp_ready),
        .busy           (busy),
        .perf_reads     (perf_reads),
        .perf_writes    (perf_writes)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", nm, obs, exp);
        end
    endtask

    // Drives one request, waits (bounded) for ready, and lets it fire on the next edge.
    task automatic issue(input logic rw, input logic [25:0] a, input logic [511:0] d,
                         input logic [63:0] be, input logic [7:0] t);
        int w;
        w = 0;
        mem_req_valid  = 1'b1;
        mem_req_rw     = rw;
        mem_req_addr   = a;
        mem_req_data   = d;
        mem_req_byteen = be;
        mem_req_tag    = t;
        while (!mem_req_ready && w < 50) begin
            tick();
            w++;
        end
        chk("req_ready_wait", mem_req_ready, 1'b1);
        tick();
        mem_req_valid = 1'b0;
        if (rw) n_wr++;
        else    n_rd++;
    endtask

    task automatic wait_rsp();
        int w;
        w = 0;
        while (!mem_rsp_valid && w < 20) begin
            tick();
            w++;
        end
        chk("rsp_wait", mem_rsp_valid, 1'b1);
    endtask

    initial begin
        int acc;
        int got;
        int issued;
        int model_out;
        int cyc;
        logic fire_req;
        logic fire_rsp;
        logic last_fire;

        pat_a  = {16{32'hA5A5_0F0F}};
        pat_b  = {8{64'h0123_4567_89AB_CDEF}};
        pat_ff = {64{8'hFF}};
        pat_b0 = {{63{8'hFF}}, 8'h00};

        reset          = 1'b1;
        mem_req_valid  = 1'b0;
        mem_req_rw     = 1'b0;
        mem_req_byteen = '0;
        mem_req_addr   = '0;
        mem_req_data   = '0;
        mem_req_tag    = '0;
        mem_rsp_ready  = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        chk("rst_req_ready",   mem_req_ready, 1'b1);
        chk("rst_rsp_valid",   mem_rsp_valid, 1'b0);
        chk("rst_busy",        busy,          1'b0);
        chk("rst_perf_reads",  perf_reads,    32'd0);
        chk("rst_perf_writes", perf_writes,   32'd0);

        // Write then read one line; response exactly 4 cycles after accept.
        issue(1'b1, 26'h5, pat_a, '1, 8'h00);
        issue(1'b0, 26'h5, '0, '0, 8'h03);
        for (int k = 1; k < 4; k++) begin
            chk("lat_early_valid", mem_rsp_valid, 1'b0);
            chk("lat_busy", busy, 1'b1);
            tick();
        end
        chk("lat_valid", mem_rsp_valid, 1'b1);
        chk("lat_data",  mem_rsp_data,  pat_a);
        chk("lat_tag",   mem_rsp_tag,   8'h03);
        chk("lat_perf_writes", perf_writes, 32'd1);
        chk("lat_perf_reads",  perf_reads,  32'd1);
        tick();
        chk("lat_valid_drop", mem_rsp_valid, 1'b0);
        chk("lat_busy_drop",  busy,          1'b0);

        // Partial byte-enable write merges into the existing line.
        issue(1'b1, 26'h7, pat_ff, '1, 8'h00);
        issue(1'b1, 26'h7, '0, 64'h1, 8'h00);
        issue(1'b0, 26'h7, '0, '0, 8'h21);
        wait_rsp();
        chk("be_data", mem_rsp_data, pat_b0);
        chk("be_tag",  mem_rsp_tag,  8'h21);
        tick();

        // 0x405 aliases onto index 0x005.
        issue(1'b1, 26'h405, pat_b, '1, 8'h00);
        issue(1'b0, 26'h005, '0, '0, 8'h44);
        wait_rsp();
        chk("alias_data", mem_rsp_data, pat_b);
        chk("alias_tag",  mem_rsp_tag,  8'h44);
        tick();
        chk("perf_writes_mid", perf_writes, 32'(n_wr));
        chk("perf_reads_mid",  perf_reads,  32'(n_rd));

        // Fill credits with responses held off; 9th read must stall.
        mem_rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            mem_req_valid = 1'b1;
            mem_req_rw    = 1'b0;
            mem_req_addr  = 26'h5;
            mem_req_tag   = 8'(acc);
            if (mem_req_ready) acc++;
            tick();
        end
        n_rd += acc;
        chk("fill_accepted",  32'(acc),      32'd8);
        chk("fill_req_ready", mem_req_ready, 1'b0);
        chk("fill_busy",      busy,          1'b1);
        chk("fill_head_tag",  mem_rsp_tag,   8'h00);
        tick();
        chk("hold_valid", mem_rsp_valid, 1'b1);
        chk("hold_tag",   mem_rsp_tag,   8'h00);
        chk("hold_data",  mem_rsp_data,  pat_b);
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            if (mem_rsp_valid) begin
                chk("drain_tag",  mem_rsp_tag,  8'(got));
                chk("drain_data", mem_rsp_data, pat_b);
                got++;
            end
            tick();
        end
        chk("drain_count",     32'(got),      32'd8);
        chk("drain_req_ready", mem_req_ready, 1'b1);
        chk("drain_busy",      busy,          1'b0);
        chk("drain_valid",     mem_rsp_valid, 1'b0);

        // Continuous reads with rsp_ready toggling every cycle.
        issued    = 0;
        got       = 0;
        model_out = 0;
        cyc       = 0;
        last_fire = 1'b0;
        while ((issued < 20 || got < 20) && cyc < 300) begin
            mem_rsp_ready = cyc[0];
            chk("tog_ready_credit", mem_req_ready, 1'(model_out < 8));
            chk("tog_busy", busy, 1'(model_out != 0));
            if (issued < 20) begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b0;
                mem_req_addr  = 26'h7;
                mem_req_tag   = 8'(8'h80 + issued);
            end else begin
                mem_req_valid = 1'b0;
            end
            fire_req = mem_req_valid && mem_req_ready;
            fire_rsp = mem_rsp_valid && mem_rsp_ready;
            if (fire_rsp) begin
                chk("tog_tag", mem_rsp_tag, 8'(8'h80 + got));
                got++;
                if (got == 20) last_fire = 1'b1;
            end
            if (fire_req) issued++;
            model_out = model_out + int'(fire_req) - int'(fire_rsp);
            chk("tog_credit_bound", 1'(model_out <= 8), 1'b1);
            tick();
            cyc++;
        end
        n_rd += issued;
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b1;
        chk("tog_all_returned", 32'(got), 32'd20);
        chk("tog_last_seen", last_fire, 1'b1);
        chk("tog_busy_after", busy, 1'b0);
        chk("tog_perf_reads", perf_reads, 32'(n_rd));

        // Reset with three reads in flight discards them.
        for (int k = 0; k < 3; k++) begin
            mem_req_valid = 1'b1;
            mem_req_rw    = 1'b0;
            mem_req_addr  = 26'h5;
            mem_req_tag   = 8'(8'h61 + k);
            chk("rst_mid_ready", mem_req_ready, 1'b1);
            tick();
        end
        mem_req_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_rd = 0;
        n_wr = 0;
        chk("rst_mid_valid", mem_rsp_valid, 1'b0);
        chk("rst_mid_busy",  busy,          1'b0);
        chk("rst_mid_ready_after", mem_req_ready, 1'b1);
        chk("rst_mid_perf_reads",  perf_reads,    32'd0);
        for (int k = 0; k < 10; k++) begin
            chk("rst_no_stale", mem_rsp_valid, 1'b0);
            tick();
        end
        issue(1'b0, 26'h7, '0, '0, 8'h77);
        for (int k = 1; k < 4; k++) begin
            chk("post_rst_early", mem_rsp_valid, 1'b0);
            tick();
        end
        chk("post_rst_valid", mem_rsp_valid, 1'b1);
        chk("post_rst_data",  mem_rsp_data,  pat_b0);
        chk("post_rst_tag",   mem_rsp_tag,   8'h77);
        chk("post_rst_perf_reads",  perf_reads,  32'(n_rd));
        chk("post_rst_perf_writes", perf_writes, 32'(n_wr));
        tick();
        chk("post_rst_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vx_mem_responder.md
Name: vx_mem_responder

Overview:
- Memory-side responder for the GPU top-level external memory port. It is the far end of the mem_req/mem_rsp handshake that the device issues.
- Accepts line-wide read and write requests into a local line-addressed RAM.
- Returns tagged read responses after a fixed latency, holding them in a bounded response queue with credit-based backpressure.
- Used as the on-chip/FPGA-sim memory model behind each memory port.

Parameters:
DATA_WIDTH, 512, line width in bits; byteen width = DATA_WIDTH/8
ADDR_WIDTH, 26, line address width of the request port
TAG_WIDTH, 8, request/response tag width
RAM_ADDR_WIDTH, 10, index bits into the local RAM (depth 2^RAM_ADDR_WIDTH lines)
LATENCY, 4, cycles from read accept to rsp_valid (queue empty, ready high); legal range 1..16
RSP_QUEUE_SIZE, 8, maximum outstanding reads (pipeline + queue); must be ≥ LATENCY

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
mem_req_valid  in  1  request valid
mem_req_rw  in  1  1 = write, 0 = read
mem_req_byteen  in  DATA_WIDTH/8  write byte enables
mem_req_addr  in  ADDR_WIDTH  line address
mem_req_data  in  DATA_WIDTH  write data
mem_req_tag  in  TAG_WIDTH  request tag
mem_req_ready  out  1  request accepted when valid&ready
mem_rsp_valid  out  1  read response valid
mem_rsp_data  out  DATA_WIDTH  read data
mem_rsp_tag  out  TAG_WIDTH  tag of the originating read
mem_rsp_ready  in  1  response consumed when valid&ready
busy  out  1  any read outstanding
perf_reads  out  32  accepted read count
perf_writes  out  32  accepted write count

Behaviour:
- Reset values: mem_rsp_valid=0, busy=0, perf_reads=0, perf_writes=0, outstanding=0, queue empty. mem_req_ready=1 in the first cycle after reset.
- RAM contents are not reset.
- RAM index = mem_req_addr[RAM_ADDR_WIDTH-1:0]. Upper address bits are ignored, so addresses alias.
- Write fire: bytes with byteen=1 are updated at the clock edge. No response is produced. perf_writes increments by 1.
- Read fire: RAM is sampled at the accept edge. Data and tag enter a LATENCY-stage delay line. perf_reads increments by 1.
- Ordering: a write accepted in cycle t is visible to a read accepted in cycle t+1 or later.
- Read response timing: if the queue is empty and mem_rsp_ready=1, a read accepted in cycle t raises mem_rsp_valid in cycle t+LATENCY.
- Responses are delivered strictly in acceptance order. There is no reordering.
- Credit counter `outstanding` (width clog2(RSP_QUEUE_SIZE+1)):
  - +1 on read fire; -1 on response fire; unchanged when both happen in the same cycle.
  - Writes never touch it.
- mem_req_ready = (outstanding < RSP_QUEUE_SIZE). This is combinational from registered state only and never depends on mem_req_valid.
- Writes are still blocked when outstanding == RSP_QUEUE_SIZE. The block has a single port, and this keeps read/write ordering.
- Response queue:
  - FIFO of RSP_QUEUE_SIZE entries, fed from the delay-line output.
  - Because the credit counter bounds outstanding reads, the queue can never overflow. Assert this in simulation.
- Output stability: while mem_rsp_valid=1 and mem_rsp_ready=0, data and tag hold stable and valid stays high.
- Simultaneous events:
  - Queue full, a response fire, and a delay-line entry arriving in the same cycle: the arriving entry is accepted (push and pop together).
  - Read accept and response fire in the same cycle leave outstanding unchanged.
- busy = (outstanding != 0).
- Perf counters wrap modulo 2^32.
- Reset mid-operation: all in-flight reads and queued responses are discarded, credits return to 0, and no response is emitted after reset.

Decomposition:
- Shared package vx_mem_model_pkg holds:
  - mem_req_t struct {rw, byteen, addr, data, tag};
  - mem_rsp_t struct {data, tag};
  - constant MEM_MODEL_CTR_W = 32.
- One natural sub-module, vx_mem_responder_queue: the parameterised FIFO with push/pop/full/empty and registered head.
- The delay line and byte-enable RAM stay inline.

Test Plan:
- Write addr 0x5 with data pattern A (byteen all 1), then read 0x5 with tag 0x3 → mem_rsp_valid exactly 4 cycles after the read accept, data=A, tag=0x3, perf_writes=1, perf_reads=1.
- Write addr 0x7 = all 0xFF, then write 0x7 with byteen=0x1 and data byte0=0x00, then read 0x7 → byte0=0x00, all other bytes 0xFF.
- Hold mem_rsp_ready=0 and issue reads back-to-back → exactly 8 accepted; mem_req_ready=0 on the 9th. Release ready → 8 responses in tag order 0..7, then ready returns to 1.
- Continuous reads with mem_rsp_ready toggling every cycle → no tag lost or duplicated; outstanding stays ≤8; busy falls to 0 one cycle after the last response fire.
- Address 0x405 with RAM_ADDR_WIDTH=10 → aliases to index 0x005: a write to 0x405 is readable at 0x005.
- Assert reset with 3 reads in flight → mem_rsp_valid=0 from the next cycle, busy=0, no stale response afterwards; a new read returns correctly after 4 cycles.
